// File: rtl/ecc_apb_sequencer.sv
// ecc_apb_sequencer: programs the ECC block over four APB writes per job, then returns its result or a timeout
module ecc_apb_sequencer #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [AMBA_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_ctrl_i,
  input  logic [AMBA_WORD-1:0]       cmd_data_i,
  input  logic [1:0]                 cmd_width_i,
  input  logic [AMBA_WORD-1:0]       cmd_noise_i,
  output logic [AMBA_ADDR_WIDTH-1:0] paddr_o,
  output logic [AMBA_WORD-1:0]       pwdata_o,
  output logic                       psel_o,
  output logic                       penable_o,
  output logic                       pwrite_o,
  input  logic                       operation_done_i,
  input  logic [DATA_WIDTH-1:0]      data_out_i,
  input  logic [1:0]                 num_of_errors_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [DATA_WIDTH-1:0]      rsp_data_o,
  output logic [1:0]                 rsp_errors_o,
  output logic                       rsp_timeout_o,
  output logic                       busy_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_DONE, RESP} state_t;
  state_t               state_q;
  logic [1:0]           idx_q, ctrl_q, width_q, idx_d;
  logic [AMBA_WORD-1:0] noise_q, wdata_d;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           off_d;
  assign idx_d = idx_q + 2'd1;
  // offsets run 4, 8, C, 0: (index + 1) * 4 wrapped to 16 bytes, which puts CTRL last
  assign off_d = {idx_d + 2'd1, 2'b00};
  assign wdata_d = idx_d == 2'd1 ? AMBA_WORD'(width_q) : idx_d == 2'd2 ? noise_q : AMBA_WORD'(ctrl_q);
  assign cmd_ready_o = state_q == IDLE;
  assign busy_o = state_q != IDLE;
  assign rsp_valid_o = state_q == RESP;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      ctrl_q <= '0;
      width_q <= '0;
      noise_q <= '0;
      cnt_q <= '0;
      paddr_o <= '0;
      pwdata_o <= '0;
      psel_o <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o <= 1'b0;
      rsp_data_o <= '0;
      rsp_errors_o <= '0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          state_q <= SETUP;
          idx_q <= '0;
          ctrl_q <= cmd_ctrl_i;
          width_q <= cmd_width_i;
          noise_q <= cmd_noise_i;
          paddr_o <= BASE_ADDR + AMBA_ADDR_WIDTH'(4'h4);
          pwdata_o <= cmd_data_i;
          psel_o <= 1'b1;
          pwrite_o <= 1'b1;
        end
        SETUP: begin
          state_q <= ACCESS;
          penable_o <= 1'b1;
        end
        ACCESS: if (idx_q != 2'd3) begin
          state_q <= SETUP;
          idx_q <= idx_d;
          paddr_o <= BASE_ADDR + AMBA_ADDR_WIDTH'(off_d);
          pwdata_o <= wdata_d;
          penable_o <= 1'b0;
        end else begin
          state_q <= WAIT_DONE;
          cnt_q <= '0;
          paddr_o <= '0;
          pwdata_o <= '0;
          psel_o <= 1'b0;
          penable_o <= 1'b0;
          pwrite_o <= 1'b0;
        end
        WAIT_DONE: if (operation_done_i) begin
          state_q <= RESP;
          rsp_data_o <= data_out_i;
          rsp_errors_o <= num_of_errors_i;
          rsp_timeout_o <= 1'b0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_q <= RESP;
          rsp_data_o <= '0;
          rsp_errors_o <= '0;
          rsp_timeout_o <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        RESP: if (rsp_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// tb_ecc_apb_sequencer: directed jobs against a scoreboard of expected APB writes and responses
module tb_ecc_apb_sequencer;
  localparam int TO = 8;
  localparam logic [19:0] BASE = 20'h0;
  typedef struct packed {logic [19:0] addr; logic [31:0] data;} wr_t;
  typedef struct packed {logic [31:0] data; logic [1:0] errs; logic to;} rsp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid, cmd_ready, psel, penable, pwrite, operation_done, rsp_valid, rsp_ready;
  logic rsp_timeout, busy;
  logic [1:0] cmd_ctrl, cmd_width, num_of_errors, rsp_errors;
  logic [31:0] cmd_data, cmd_noise, pwdata, data_out, rsp_data;
  logic [19:0] paddr;
  wr_t wq[$];
  rsp_t rq[$];
  int passed = 0, fails = 0, total = 0;
  always #5 clk = ~clk;
  ecc_apb_sequencer #(.AMBA_ADDR_WIDTH(20), .AMBA_WORD(32), .DATA_WIDTH(32), .BASE_ADDR(BASE),
                      .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_ctrl_i(cmd_ctrl),
    .cmd_data_i(cmd_data), .cmd_width_i(cmd_width), .cmd_noise_i(cmd_noise), .paddr_o(paddr),
    .pwdata_o(pwdata), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .operation_done_i(operation_done), .data_out_i(data_out), .num_of_errors_i(num_of_errors),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_errors_o(rsp_errors), .rsp_timeout_o(rsp_timeout), .busy_o(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  // APB monitor: SETUP peeks the next expected write, ACCESS retires it
  always @(negedge clk) begin
    if (psel) begin
      if (wq.size() == 0) chk("apb_unexpected_write", psel, 1'b0);
      else begin
        chk(penable ? "apb_access_addr" : "apb_setup_addr", paddr, wq[0].addr);
        chk(penable ? "apb_access_data" : "apb_setup_data", pwdata, wq[0].data);
        chk("apb_pwrite", pwrite, 1'b1);
        if (penable) void'(wq.pop_front());
      end
    end else chk("apb_idle", {penable, pwrite, paddr, pwdata}, 64'h0);
  end
  task automatic run_job(input logic [1:0] ctrl, input logic [1:0] width, input logic [31:0] data,
                         input logic [31:0] noise, input int done_at, input int stray_at,
                         input logic [31:0] dout, input logic [1:0] errs, input int hold);
    int k, lat;
    bit to;
    rsp_t e;
    to = (done_at == 0);
    lat = to ? 9 + TO : done_at + 1;
    wq.push_back(wr_t'({BASE + 20'h4, data}));
    wq.push_back(wr_t'({BASE + 20'h8, 30'h0, width}));
    wq.push_back(wr_t'({BASE + 20'hC, noise}));
    wq.push_back(wr_t'({BASE, 30'h0, ctrl}));
    rq.push_back(to ? rsp_t'({32'h0, 2'b00, 1'b1}) : rsp_t'({dout, errs, 1'b0}));
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_ctrl = ctrl; cmd_width = width; cmd_data = data; cmd_noise = noise;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    k = 1;
    chk("busy_after_accept", {busy, cmd_ready}, 2'b10);
    while (!rsp_valid && k <= 9 + TO + 4) begin
      operation_done = (k == done_at) || (k == stray_at);
      data_out = (k == done_at) ? dout : ~dout;
      num_of_errors = (k == done_at) ? errs : ~errs;
      @(posedge clk); #1;
      k++;
    end
    operation_done = 1'b0;
    chk("rsp_latency", k, lat);
    chk("rsp_valid", rsp_valid, 1'b1);
    e = rq.pop_front();
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_errors", rsp_errors, e.errs);
    chk("rsp_timeout", rsp_timeout, e.to);
    chk("resp_cmd_ready", {cmd_ready, busy}, 2'b01);
    if (hold > 0) cmd_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_payload", {rsp_data, rsp_errors, rsp_timeout}, {e.data, e.errs, e.to});
      chk("hold_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("after_rsp_idle", {rsp_valid, cmd_ready, busy}, 3'b010);
  endtask
  task automatic reset_mid_job();
    wq.push_back(wr_t'({BASE + 20'h4, 32'h11}));
    wq.push_back(wr_t'({BASE + 20'h8, 32'h1}));
    wq.push_back(wr_t'({BASE + 20'hC, 32'h22}));
    cmd_valid = 1'b1; cmd_ctrl = 2'b01; cmd_width = 2'b01; cmd_data = 32'h11; cmd_noise = 32'h22;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("noise_access_phase", {psel, penable, paddr}, {2'b11, BASE + 20'hC});
    #1 rst = 1'b1;
    #1;
    chk("rst_apb_zero", {psel, penable, pwrite}, 3'b000);
    chk("rst_state", {cmd_ready, busy, rsp_valid}, 3'b100);
    chk("rst_pending_writes", wq.size(), 1);
    wq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", {cmd_ready, psel}, 2'b10);
  endtask
  initial begin
    cmd_valid = 1'b0; cmd_ctrl = '0; cmd_width = '0; cmd_data = '0; cmd_noise = '0;
    operation_done = 1'b0; data_out = '0; num_of_errors = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {cmd_ready, busy, rsp_valid}, 3'b100);
    chk("reset_rsp", {rsp_data, rsp_errors, rsp_timeout}, 35'h0);
    chk("reset_apb", {psel, penable, pwrite, paddr, pwdata}, 55'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_job(2'b00, 2'b00, 32'h5, 32'h0, 11, 0, 32'h5A, 2'd0, 0);
    run_job(2'b10, 2'b10, 32'hDEADBEEF, 32'h3, 11, 0, 32'h12345678, 2'd2, 0);
    run_job(2'b01, 2'b01, 32'hABCD, 32'h0, 0, 0, 32'hFFFF, 2'd1, 0);
    run_job(2'b01, 2'b01, 32'h1357, 32'h8, TO + 8, 0, 32'h77, 2'd1, 0);
    run_job(2'b11, 2'b00, 32'hC3, 32'h80, 13, 0, 32'hA5A5, 2'd3, 5);
    run_job(2'b00, 2'b01, 32'h42, 32'h1, 10, 0, 32'h600D, 2'd0, 0);
    reset_mid_job();
    run_job(2'b00, 2'b10, 32'h1, 32'h4, 11, 3, 32'h99, 2'd0, 0);
    chk("scoreboard_empty", {wq.size(), rq.size()}, 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ecc_apb_sequencer.md
# ecc_apb_sequencer

Command sequencer directly upstream of the ECC encoder/decoder. It accepts one job per valid/ready handshake: operation, data word, codeword width and noise pattern. It programs the ECC block over APB with four register writes, CTRL last because the CTRL write starts the operation. It then waits for `operation_done`, captures `data_out` and `num_of_errors`, and returns them on a held response interface. A timeout reports a hung ECC block instead of stalling forever.

## Interface
- `AMBA_ADDR_WIDTH`, default 20: APB address width.
- `AMBA_WORD`, default 32: APB data width.
- `DATA_WIDTH`, default 32: width of the ECC `data_out`.
- `BASE_ADDR`, default 0: ECC register base address, aligned to 16 bytes.
- `TIMEOUT_CYCLES`, default 16: maximum number of WAIT_DONE cycles, ≥1.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `cmd_valid`  in  1: job offered.
- `cmd_ready`  out  1: high only in IDLE.
- `cmd_ctrl`  in  2: 00 encode, 01 decode, 10 full channel; 11 is passed through unchanged.
- `cmd_data`  in  AMBA_WORD: DATA_IN value.
- `cmd_width`  in  2: CODEWORD_WIDTH, 00 = 8, 01 = 16, 10 = 32.
- `cmd_noise`  in  AMBA_WORD: NOISE value.
- `PADDR`  out  AMBA_ADDR_WIDTH; `PWDATA`  out  AMBA_WORD; `PSEL`, `PENABLE`, `PWRITE`  out  1 each: APB master.
- `operation_done`  in  1; `data_out`  in  DATA_WIDTH; `num_of_errors`  in  2: ECC results.
- `rsp_valid`  out  1; `rsp_ready`  in  1: response handshake.
- `rsp_data`  out  DATA_WIDTH; `rsp_errors`  out  2; `rsp_timeout`  out  1: response payload.
- `busy`  out  1: high in every state except IDLE.

## Operation
- **States:**
  - IDLE: waits for a job.
  - SETUP and ACCESS: carry one APB write each.
  - WAIT_DONE: waits for the ECC result.
  - RESP: holds the response.
- **Job capture:** when `cmd_valid & cmd_ready`, all `cmd_*` fields are latched and the state moves to SETUP with write index 0.
- **Write sequence (index: register, address, PWDATA):**
  - 0: DATA_IN, BASE_ADDR+0x4, `cmd_data`.
  - 1: CODEWORD_WIDTH, BASE_ADDR+0x8, `{zeros, cmd_width}`.
  - 2: NOISE, BASE_ADDR+0xC, `cmd_noise`.
  - 3: CTRL, BASE_ADDR+0x0, `{zeros, cmd_ctrl}`.
- **SETUP:** PSEL=1, PENABLE=0, PWRITE=1, with PADDR/PWDATA set for the current index.
- **ACCESS:** PSEL=1 and PENABLE=1; PADDR, PWDATA and PWRITE are unchanged from SETUP.
- **After ACCESS:** if index<3, increment the index and go to SETUP; otherwise go to WAIT_DONE with the timeout counter cleared.
- **No wait states:** the slave has no PREADY, so every ACCESS lasts exactly one cycle.
- **Bus idle values:** outside SETUP/ACCESS, PSEL=PENABLE=PWRITE=0 and PADDR=PWDATA=0. All APB outputs are registered.
- **WAIT_DONE, done seen:** if `operation_done`=1 in a cycle, capture `rsp_data`←`data_out`, `rsp_errors`←`num_of_errors`, `rsp_timeout`←0, and go to RESP.
- **WAIT_DONE, no done:** if the counter equals TIMEOUT_CYCLES-1, set `rsp_data`=0, `rsp_errors`=0, `rsp_timeout`=1, and go to RESP. Otherwise increment the counter.
- **Done vs. timeout:** if `operation_done` and the timeout limit occur in the same cycle, `operation_done` wins.
- **Done outside WAIT_DONE:** `operation_done` is ignored.
- **RESP:** `rsp_valid`=1 with a stable payload until `rsp_ready`=1; then go to IDLE. `cmd_ready` stays 0 throughout RESP.
- **Counter width:** `$clog2(TIMEOUT_CYCLES+1)`; no wrap is possible.

## Timing
- **Reset values:** state IDLE, cmd_ready=1, busy=0, all APB outputs 0, rsp_valid=0, rsp_data=0, rsp_errors=0, rsp_timeout=0.
- **Reset mid-operation:** asserting `rst` at any point forces the reset values asynchronously. An in-flight APB transfer is abandoned and any pending response is discarded.
- **Write schedule, handshake in cycle T:**
  - DATA_IN write: SETUP in T+1, ACCESS in T+2.
  - CODEWORD_WIDTH write: T+3 and T+4.
  - NOISE write: T+5 and T+6.
  - CTRL write: T+7 and T+8. The ECC start is seen in T+8.
- **Wait window:** WAIT_DONE begins at T+9 and lasts at most TIMEOUT_CYCLES cycles.
- **Response latency:** `rsp_valid` rises one cycle after `operation_done` is sampled high. With an ECC that asserts done at T+11, `rsp_valid` is high at T+12.
- **Back-to-back jobs:** `rsp_ready` high in the first RESP cycle returns the block to IDLE on the next cycle, so the next job can be accepted 1 cycle after the response. Minimum job period is 11 cycles plus the ECC latency.
- **Reading from outside:** PWRITE=0 while the bus is idle, so the ECC PRDATA register may update; this is harmless.

## Test plan
- **Encode:** reset, then job ctrl=00, width=00, data=0x5, noise=0. Required: the APB trace writes 0x4→0x5, 0x8→0x0, 0xC→0x0, 0x0→0x0 in order, each as 2 cycles with SETUP/ACCESS phases correct. With the model returning done at T+11, data_out=0x5A and errors=0, the response is rsp_data=0x5A, rsp_errors=0, rsp_timeout=0.
- **Full channel:** job ctrl=10, width=10, noise=0x00000003. Required: PWDATA at 0xC equals 0x3 and at 0x0 equals 0x2. Model errors=2 is returned as rsp_errors=2.
- **Timeout:** operation_done held at 0. Required: rsp_timeout=1, rsp_data=0, rsp_valid rising exactly TIMEOUT_CYCLES cycles after WAIT_DONE entry. Also assert done in the final wait cycle and require timeout=0.
- **Backpressure:** rsp_ready low for 5 cycles. Required: rsp_valid and the payload held stable, cmd_ready=0, and a second cmd_valid not accepted until 1 cycle after rsp_ready.
- **Reset mid-job:** assert rst during the NOISE ACCESS cycle. Required: PSEL, PENABLE and PWRITE go to 0 immediately, no CTRL write occurs, and after release cmd_ready=1 and the next job runs normally.
- **Stray done:** pulse operation_done during the write phase. Required: it is ignored and the response comes from the done pulse in WAIT_DONE.
